md_seq_unit: RTL and testbench

Sequential multiply/divide unit with a start/busy handshake toward the execute stage. It owns the HI/LO register pair and serves mult/multu/div/divu plus mthi/mtlo/mfhi/mflo. It iterates over 32 cycles, so the pipeline must hold any dependent instruction. It raises `stall` whenever the pipeline touches HI/LO while an operation is in flight, so the pipeline needs no separate HI/LO hazard logic.

---
 rtl/md_seq_unit.sv | 136 +++++++++++++
 tb/tb_md_seq_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/md_seq_unit.sv
// Sequential 32-bit multiply/divide unit that owns HI/LO; 33-cycle latency with a start/busy handshake.
// Optional abort of an in-flight op is enabled by defining MD_CANCEL_EN.
module md_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr,
    input  logic        sel,
    input  logic [31:0] data,
    input  logic        rd,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] H32,
    output logic [31:0] L32
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        is_div, q_neg, r_neg, dz;
    logic [31:0] mcand;          // multiplicand or divisor magnitude
    logic [63:0] acc;            // product, or dividend/quotient in the low half
    logic [31:0] rem;
    logic [31:0] hi, lo;
    logic        abort;

    logic        sgn;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sum, rem_sh;
    logic        ge;
    logic [31:0] diff;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | wr | rd);
    assign H32   = hi;
    assign L32   = lo;

`ifdef MD_CANCEL_EN
    assign abort = cancel & busy;
`else
    assign abort = 1'b0;
`endif

    assign sgn   = ~op[0];
    assign a_mag = (sgn && a[31]) ? -a : a;
    assign b_mag = (sgn && b[31]) ? -b : b;

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    assign sum    = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'd0)};
    // Restoring step: bring in the next dividend bit and try to subtract.
    assign rem_sh = {rem, acc[31]};
    assign ge     = (rem_sh >= {1'b0, mcand});
    assign diff   = rem_sh[31:0] - mcand;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            rem    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        q_neg  <= sgn & (a[31] ^ b[31]);
                        r_neg  <= sgn & a[31];
                        dz     <= (b == 32'd0);
                        rem    <= '0;
                        if (op[1]) begin
                            acc   <= {32'd0, a_mag};
                            mcand <= b_mag;
                        end else begin
                            acc   <= {32'd0, b_mag};
                            mcand <= a_mag;
                        end
                    end else if (wr) begin
                        if (sel) hi <= data;
                        else     lo <= data;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        rem        <= ge ? diff : rem_sh[31:0];
                        acc[31:0]  <= {acc[30:0], ge};
                    end else begin
                        acc <= {sum, acc[31:1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        if (is_div) begin
                            lo <= dz ? 32'hFFFF_FFFF : (q_neg ? -acc[31:0] : acc[31:0]);
                            hi <= r_neg ? -rem : rem;
                        end else begin
                            {hi, lo} <= q_neg ? -acc : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_seq_unit.sv
// Bench for md_seq_unit: directed and random ops checked against an arithmetic HI/LO model.
// Define MD_CANCEL_EN on both bench and RTL to exercise the cancel path.
module tb_md_seq_unit;

    logic        clk = 1'b0;
    logic        rst, start, wr, sel, rd, cancel;
    logic [1:0]  op;
    logic [31:0] a, b, data;
    logic        busy, stall;
    logic [31:0] H32, L32;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    md_seq_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr(wr), .sel(sel), .data(data), .rd(rd),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .stall(stall), .H32(H32), .L32(L32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint q, r;
        longint unsigned p;
        case (o)
            2'd0: begin p = sx * sy; return p; end
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                p = ux / uy;
                q = longint'(ux % uy);
                return {q[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Issue one op at posedge+1, poke hazards while busy, check latency and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string tag);
        int n;
        logic s;
        op = o; a = x; b = y; start = 1'b1;
        #1;
        chk({tag, "_issue_stall"}, stall, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0; wr = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            rd    = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            s     = 1'($urandom_range(0, 1));
            start = s;
            sel   = 1'($urandom_range(0, 1));
            data  = $urandom;
            op    = 2'($urandom_range(0, 3));
            #1;
            chk({tag, "_stall"}, stall, rd | wr | s);
            chk({tag, "_hold"}, {H32, L32}, {m_hi, m_lo});
            @(posedge clk); #1;
            n++;
            rd = 1'b0; wr = 1'b0; start = 1'b0;
        end
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_hilo"}, {H32, L32}, exp);
        {m_hi, m_lo} = exp;
    endtask

    logic [1:0]  d_op  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic [31:0] d_a   [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] d_b   [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] d_exp [6] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFE_0000_0001,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0064_FFFF_FFFF,
                               64'h0000_0000_8000_0000, 64'hFFFF_FFF9_FFFF_FFFF};

    initial begin
        rst = 1'b1; start = 1'b0; wr = 1'b0; sel = 1'b0; rd = 1'b0; cancel = 1'b0;
        op = 2'd0; a = '0; b = '0; data = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_hilo", {H32, L32}, 64'd0);
        rd = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            chk($sformatf("model_%0d", i), ref_md(d_op[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_op[i], d_a[i], d_b[i], d_exp[i], $sformatf("dir%0d", i));
        end

        // mthi/mtlo in IDLE touch only the selected half.
        wr = 1'b1; sel = 1'b1; data = 32'h1234;
        @(posedge clk); #1;
        wr = 1'b0;
        m_hi = 32'h1234;
        chk("mthi", {H32, L32}, {m_hi, m_lo});
        wr = 1'b1; sel = 1'b0; data = 32'h5678_9ABC;
        @(posedge clk); #1;
        wr = 1'b0;
        m_lo = 32'h5678_9ABC;
        chk("mtlo", {H32, L32}, {m_hi, m_lo});

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i == 3) rb = 32'd1;
            if (i == 5) ra = 32'h8000_0000;
            run_op(ro, ra, rb, ref_md(ro, ra, rb), $sformatf("rnd%0d", i));
        end

        // Synchronous reset in the middle of CALC.
        op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hilo", {H32, L32}, 64'd0);
        run_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, ref_md(2'd0, 32'h7FFF_FFFF, 32'h8000_0000), "post_rst");

`ifdef MD_CANCEL_EN
        // start with a simultaneous write, then cancel: no write, no result.
        op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
        wr = 1'b1; sel = 1'b1; data = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", busy, 1'b0);
        chk("cancel_hilo", {H32, L32}, {m_hi, m_lo});
        cancel = 1'b1;
        run_op(2'd3, 32'd1000, 32'd7, ref_md(2'd3, 32'd1000, 32'd7), "cancel_start");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
